// File: rtl/chipbus_ctrl.sv
// Local-bus sequencer for two YM2203s and one SAA1099: CS/A0/data setup, strobe, hold and per-chip recovery.
// Latency: CS falls two cycles after a request is accepted for an idle chip; every output is registered.
// Backpressure: rdy stays low for the whole access; the requester holds req until it is accepted.
module chipbus_ctrl #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 8,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_REC_YM  = 112,
  parameter int unsigned T_REC_SAA = 4
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       req,
  output logic       rdy,
  input  logic [1:0] req_tgt,
  input  logic       req_wr,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  output logic       ymcs1_n,
  output logic       ymcs2_n,
  output logic       ymwr_n,
  output logic       ymrd_n,
  output logic       yma0,
  output logic       saacs_n,
  output logic       saawr_n,
  output logic       saaa0
);

  localparam logic [1:0] TGT_YM1 = 2'd0;
  localparam logic [1:0] TGT_YM2 = 2'd1;
  localparam logic [1:0] TGT_SAA = 2'd2;
  localparam logic [1:0] TGT_RSV = 2'd3;

  // Timers count down to zero, so each phase loads its length minus one.
  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);
  localparam logic [7:0] REC_YM   = 8'(T_REC_YM);
  localparam logic [7:0] REC_SAA  = 8'(T_REC_SAA);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] tgt_q;
  logic       wr_q, a0_q;
  logic [7:0] data_q;
  logic [7:0] rec_ym1_q, rec_ym2_q, rec_saa_q;

  logic       rdy_q, rdy_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       ymcs1_n_q, ymcs1_n_d, ymcs2_n_q, ymcs2_n_d;
  logic       ymwr_n_q, ymwr_n_d, ymrd_n_q, ymrd_n_d, yma0_q, yma0_d;
  logic       saacs_n_q, saacs_n_d, saawr_n_q, saawr_n_d, saaa0_q, saaa0_d;

  logic accept, drop, tgt_busy, leave_hold, active, is_ym, is_saa, strobe;

  assign accept     = req && rdy_q;
  // Reserved target and SAA reads never touch the bus.
  assign drop       = (tgt_q == TGT_RSV) || ((tgt_q == TGT_SAA) && !wr_q);
  assign leave_hold = (state_q == S_HOLD) && (timer_q == 8'd0);
  assign active     = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign strobe     = (state_q == S_STROBE);
  assign is_ym      = (tgt_q == TGT_YM1) || (tgt_q == TGT_YM2);
  assign is_saa     = (tgt_q == TGT_SAA);

  // Select the recovery counter of the latched target
  always_comb begin
    tgt_busy = 1'b0;
    case (tgt_q)
      TGT_YM1: tgt_busy = (rec_ym1_q != 8'd0);
      TGT_YM2: tgt_busy = (rec_ym2_q != 8'd0);
      TGT_SAA: tgt_busy = (rec_saa_q != 8'd0);
      default: tgt_busy = 1'b0;
    endcase
  end

  // State and phase timer register
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state; the phase timer reloads on every entry into a timed state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (drop) begin
          state_d = S_IDLE;
        end else if (!tgt_busy) begin
          state_d = S_SETUP;
          timer_d = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (timer_q == 8'd0) begin
          state_d = S_STROBE;
          timer_d = PULSE_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (timer_q == 8'd0) begin
          state_d = S_HOLD;
          timer_d = HOLD_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (timer_q == 8'd0) state_d = S_IDLE;
        else                 timer_d = timer_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, captured only on an accepted handshake
  always_ff @(posedge fclk) begin
    if (rst) begin
      tgt_q  <= TGT_YM1;
      wr_q   <= 1'b0;
      a0_q   <= 1'b0;
      data_q <= 8'h00;
    end else if (accept) begin
      tgt_q  <= req_tgt;
      wr_q   <= req_wr;
      a0_q   <= req_a0;
      data_q <= req_data;
    end
  end

  // Per-chip recovery: load on leaving HOLD, otherwise count down to zero
  always_ff @(posedge fclk) begin
    if (rst) begin
      rec_ym1_q <= 8'd0;
      rec_ym2_q <= 8'd0;
      rec_saa_q <= 8'd0;
    end else begin
      if (leave_hold && (tgt_q == TGT_YM1)) rec_ym1_q <= REC_YM;
      else if (rec_ym1_q != 8'd0)           rec_ym1_q <= rec_ym1_q - 8'd1;
      if (leave_hold && (tgt_q == TGT_YM2)) rec_ym2_q <= REC_YM;
      else if (rec_ym2_q != 8'd0)           rec_ym2_q <= rec_ym2_q - 8'd1;
      if (leave_hold && (tgt_q == TGT_SAA)) rec_saa_q <= REC_SAA;
      else if (rec_saa_q != 8'd0)           rec_saa_q <= rec_saa_q - 8'd1;
    end
  end

  // Output decode from the current state; registered one cycle later
  always_comb begin
    rdy_d      = (state_d == S_IDLE);
    ymcs1_n_d  = !(active && (tgt_q == TGT_YM1));
    ymcs2_n_d  = !(active && (tgt_q == TGT_YM2));
    saacs_n_d  = !(active && is_saa);
    ymwr_n_d   = !(strobe && is_ym && wr_q);
    ymrd_n_d   = !(strobe && is_ym && !wr_q);
    saawr_n_d  = !(strobe && is_saa && wr_q);
    yma0_d     = active && is_ym && a0_q;
    saaa0_d    = active && is_saa && a0_q;
    d_oe_d     = active && wr_q;
    d_out_d    = (active && wr_q) ? data_q : 8'h00;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (strobe && (timer_q == 8'd0) && !wr_q) rd_data_d = d_in;
    if ((state_q == S_HOLD) && (timer_q == HOLD_LD) && !wr_q) rd_valid_d = 1'b1;
    if ((state_q == S_WAIT) && drop && !wr_q) begin
      rd_data_d  = 8'hFF;
      rd_valid_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge fclk) begin
    if (rst) begin
      rdy_q      <= 1'b1;
      rd_data_q  <= 8'hFF;
      rd_valid_q <= 1'b0;
      d_out_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      ymcs1_n_q  <= 1'b1;
      ymcs2_n_q  <= 1'b1;
      ymwr_n_q   <= 1'b1;
      ymrd_n_q   <= 1'b1;
      yma0_q     <= 1'b0;
      saacs_n_q  <= 1'b1;
      saawr_n_q  <= 1'b1;
      saaa0_q    <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      ymcs1_n_q  <= ymcs1_n_d;
      ymcs2_n_q  <= ymcs2_n_d;
      ymwr_n_q   <= ymwr_n_d;
      ymrd_n_q   <= ymrd_n_d;
      yma0_q     <= yma0_d;
      saacs_n_q  <= saacs_n_d;
      saawr_n_q  <= saawr_n_d;
      saaa0_q    <= saaa0_d;
    end
  end

  assign rdy      = rdy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign d_out    = d_out_q;
  assign d_oe     = d_oe_q;
  assign ymcs1_n  = ymcs1_n_q;
  assign ymcs2_n  = ymcs2_n_q;
  assign ymwr_n   = ymwr_n_q;
  assign ymrd_n   = ymrd_n_q;
  assign yma0     = yma0_q;
  assign saacs_n  = saacs_n_q;
  assign saawr_n  = saawr_n_q;
  assign saaa0    = saaa0_q;

endmodule

// File: tb/tb_chipbus_ctrl.sv
// Bench for chipbus_ctrl: vector table, hand sequences for recovery/reset, and a long back-to-back run.
// Bus windows and read pulses are matched against queues filled when each request is accepted.
module tb_chipbus_ctrl;

  logic       fclk, rst, req, rdy;
  logic [1:0] req_tgt;
  logic       req_wr, req_a0;
  logic [7:0] req_data, rd_data, d_out, d_in;
  logic       rd_valid, d_oe;
  logic       ymcs1_n, ymcs2_n, ymwr_n, ymrd_n, yma0, saacs_n, saawr_n, saaa0;

  chipbus_ctrl dut (
    .fclk(fclk), .rst(rst), .req(req), .rdy(rdy), .req_tgt(req_tgt), .req_wr(req_wr),
    .req_a0(req_a0), .req_data(req_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .ymcs1_n(ymcs1_n), .ymcs2_n(ymcs2_n),
    .ymwr_n(ymwr_n), .ymrd_n(ymrd_n), .yma0(yma0), .saacs_n(saacs_n), .saawr_n(saawr_n),
    .saaa0(saaa0)
  );

  typedef struct {
    logic [1:0] tgt; logic wr; logic a0; logic [7:0] data; logic [7:0] din;
    int exp_bus; int exp_rdv; logic [7:0] exp_rd; int exp_lat; int rdy_min; int rdy_max;
  } vec_t;
  typedef struct { logic [1:0] tgt; logic wr; logic a0; logic [7:0] data; logic [7:0] din; } bus_t;
  typedef struct { logic [7:0] val; logic bus; } rd_t;

  bus_t busq[$];
  rd_t  rdq[$];

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0;
  int bus_cnt = 0, rdv_cnt = 0;
  int rdy_low_run = 0, last_rdy_low = 0;
  int fall_cyc[3], rel_cyc[3], gap[3];
  logic [7:0] last_rd;
  logic mon_en = 0, abort_pending = 0;

  // monitor window state
  logic       in_win = 0;
  int         win_chip, win_len, stb_len, stb_first;
  logic       stb_wr, w_bad, w_stray, w_a0, w_oe;
  logic [7:0] w_dout;
  logic       prev_rdv = 0, prev_ymrd_n = 1;
  logic [2:0] csv;
  logic       a0v, wlo, rlo, stray;
  bus_t       be;
  rd_t        re;

  initial begin
    fclk = 0;
    forever #5 fclk = ~fclk;
  end

  always @(posedge fclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus monitor and scoreboard consumer
  always @(negedge fclk) begin
    if (mon_en) begin
      csv = {~saacs_n, ~ymcs2_n, ~ymcs1_n};
      if (csv != 3'b000) chk("one_cs", $countones(csv), 1);
      if (csv == 3'b000) chk("strobe_outside_cs", {ymwr_n, ymrd_n, saawr_n}, 7);
      if (!in_win && csv != 3'b000) begin
        in_win = 1;
        win_chip = csv[0] ? 0 : (csv[1] ? 1 : 2);
        win_len = 0; stb_len = 0; stb_first = -1; stb_wr = 0; w_bad = 0; w_stray = 0;
        gap[win_chip] = cyc - rel_cyc[win_chip];
        fall_cyc[win_chip] = cyc;
        w_a0 = (win_chip == 2) ? saaa0 : yma0;
        w_oe = d_oe;
        w_dout = d_out;
      end
      if (in_win && csv != 3'b000) begin
        a0v   = (win_chip == 2) ? saaa0 : yma0;
        wlo   = (win_chip == 2) ? !saawr_n : !ymwr_n;
        rlo   = (win_chip != 2) && !ymrd_n;
        stray = (win_chip == 2) ? (!ymwr_n || !ymrd_n) : !saawr_n;
        if (a0v != w_a0 || d_oe != w_oe || d_out != w_dout) w_bad = 1;
        if (stray) w_stray = 1;
        if (wlo || rlo) begin
          if (stb_len == 0) stb_first = win_len;
          stb_len++;
          stb_wr = wlo;
        end
        win_len++;
      end else if (in_win) begin
        in_win = 0;
        rel_cyc[win_chip] = cyc;
        if (abort_pending) begin
          abort_pending = 0;
          if (busq.size() != 0) void'(busq.pop_front());
        end else if (busq.size() == 0) begin
          chk("bus_unexpected_window", 1, 0);
        end else begin
          be = busq.pop_front();
          bus_cnt++;
          chk("bus_target", win_chip, be.tgt);
          chk("bus_strobe_is_write", stb_wr, be.wr);
          chk("bus_a0", w_a0, be.a0);
          chk("bus_cs_len", win_len, 12);
          chk("bus_strobe_len", stb_len, 8);
          chk("bus_strobe_offset", stb_first, 2);
          chk("bus_d_oe", w_oe, be.wr);
          chk("bus_held_stable", w_bad, 0);
          chk("bus_stray_strobe", w_stray, 0);
          if (be.wr) chk("bus_d_out", w_dout, be.data);
        end
      end
      if (rd_valid) begin
        chk("rd_valid_single", prev_rdv, 0);
        if (rdq.size() == 0) chk("rd_valid_unexpected", 1, 0);
        else begin
          re = rdq.pop_front();
          rdv_cnt++;
          last_rd = rd_data;
          chk("rd_data", rd_data, re.val);
          if (re.bus) chk("rd_valid_after_rd_rise", {prev_ymrd_n, ymrd_n}, 2'b01);
        end
      end
      if (!rdy) rdy_low_run++;
      else begin
        if (rdy_low_run != 0) last_rdy_low = rdy_low_run;
        rdy_low_run = 0;
      end
      prev_rdv = rd_valid;
      prev_ymrd_n = ymrd_n;
    end
    d_in = (busq.size() != 0) ? busq[0].din : 8'h00;
  end

  task automatic step();
    @(negedge fclk);
    #1;
  endtask

  // Present a request and hold it until the coming edge accepts it
  task automatic issue(input logic [1:0] t, input logic w, input logic a,
                       input logic [7:0] dt, input logic [7:0] di);
    int n;
    logic drop;
    bus_t b;
    rd_t r;
    step();
    req_tgt = t; req_wr = w; req_a0 = a; req_data = dt; req = 1;
    n = 0;
    while (!rdy && n < 600) begin
      step();
      n++;
    end
    if (!rdy) begin
      chk("issue_timeout", 0, 1);
      req = 0;
    end else begin
      acc_cyc = cyc + 1;
      drop = (t == 2'd3) || (t == 2'd2 && !w);
      if (!drop) begin
        b = '{t, w, a, dt, di};
        busq.push_back(b);
      end
      if (!w) begin
        r = '{drop ? 8'hFF : di, !drop};
        rdq.push_back(r);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    step();
    req = 0;
    n = 0;
    while (!(rdy && busq.size() == 0 && rdq.size() == 0 && !in_win) && n < 600) begin
      step();
      n++;
    end
    if (n >= 600) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int b0, r0, exp_b, exp_r;
    logic [1:0] t;
    logic w;
    int n;

    vt[0] = '{2'd0, 1'b1, 1'b0, 8'h27, 8'h00, 1, 0, 8'h00, 2, 13, 13};
    vt[1] = '{2'd1, 1'b0, 1'b1, 8'h00, 8'h5A, 1, 1, 8'h5A, 0, 1, 300};
    vt[2] = '{2'd2, 1'b0, 1'b0, 8'h00, 8'h11, 0, 1, 8'hFF, 0, 1, 2};
    vt[3] = '{2'd3, 1'b0, 1'b1, 8'h00, 8'h22, 0, 1, 8'hFF, 0, 1, 2};
    vt[4] = '{2'd3, 1'b1, 1'b0, 8'h99, 8'h00, 0, 0, 8'h00, 0, 1, 2};
    vt[5] = '{2'd2, 1'b1, 1'b1, 8'h81, 8'h00, 1, 0, 8'h00, 0, 1, 300};
    vt[6] = '{2'd0, 1'b0, 1'b1, 8'h00, 8'hC3, 1, 1, 8'hC3, 0, 1, 300};
    vt[7] = '{2'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 300};

    rst = 1; req = 0; req_tgt = 0; req_wr = 0; req_a0 = 0; req_data = 0;
    for (int i = 0; i < 3; i++) rel_cyc[i] = 0;
    repeat (3) step();
    chk("rst_n_outputs", {ymcs1_n, ymcs2_n, ymwr_n, ymrd_n, saacs_n, saawr_n}, 6'b111111);
    chk("rst_a0_oe", {yma0, saaa0, d_oe}, 3'b000);
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_rd_data", rd_data, 8'hFF);
    chk("rst_rdy_rdv", {rdy, rd_valid}, 2'b10);
    rst = 0;
    mon_en = 1;

    // table-driven single requests
    for (int i = 0; i < 8; i++) begin
      b0 = bus_cnt; r0 = rdv_cnt;
      issue(vt[i].tgt, vt[i].wr, vt[i].a0, vt[i].data, vt[i].din);
      wait_idle();
      chk("vec_bus_windows", bus_cnt - b0, vt[i].exp_bus);
      chk("vec_rd_pulses", rdv_cnt - r0, vt[i].exp_rdv);
      if (vt[i].exp_rdv != 0) chk("vec_rd_data", last_rd, vt[i].exp_rd);
      if (vt[i].exp_lat != 0) chk("vec_cs_latency", fall_cyc[vt[i].tgt] - acc_cyc, vt[i].exp_lat);
      chk("vec_rdy_low_in_range", (last_rdy_low >= vt[i].rdy_min) && (last_rdy_low <= vt[i].rdy_max), 1);
    end

    // back-to-back to the same YM: recovery must separate the two windows
    repeat (130) step();
    issue(2'd0, 1'b1, 1'b0, 8'h11, 8'h00);
    issue(2'd0, 1'b1, 1'b1, 8'h22, 8'h00);
    wait_idle();
    chk("ym1_recovery_min", gap[0] >= 112, 1);
    chk("ym1_recovery_max", gap[0] <= 116, 1);

    // YM1 then YM2: the other chip is idle, so no recovery wait
    repeat (130) step();
    issue(2'd0, 1'b1, 1'b0, 8'h33, 8'h00);
    issue(2'd1, 1'b1, 1'b1, 8'h44, 8'h00);
    wait_idle();
    chk("ym2_no_wait", (fall_cyc[1] - rel_cyc[0] >= 1) && (fall_cyc[1] - rel_cyc[0] <= 4), 1);

    // reset in the middle of an SAA write strobe
    issue(2'd2, 1'b1, 1'b1, 8'h3C, 8'h00);
    n = 0;
    while (saawr_n && n < 200) begin
      step();
      n++;
    end
    chk("reset_reached_strobe", saawr_n, 0);
    abort_pending = 1;
    rst = 1;
    req = 0;
    step();
    chk("mid_rst_saa_released", {saacs_n, saawr_n}, 2'b11);
    chk("mid_rst_oe_rdy_rdv", {d_oe, rdy, rd_valid}, 3'b010);
    rst = 0;
    issue(2'd2, 1'b1, 1'b0, 8'hA5, 8'h00);
    wait_idle();
    chk("post_rst_saa_latency", fall_cyc[2] - acc_cyc, 2);

    // long run with req held and rotating targets
    b0 = bus_cnt; r0 = rdv_cnt; exp_b = 0; exp_r = 0;
    for (int i = 0; i < 1000; i++) begin
      t = 2'(i % 4);
      w = 1'($urandom_range(1, 0));
      if (!((t == 2'd3) || (t == 2'd2 && !w))) exp_b++;
      if (!w) exp_r++;
      issue(t, w, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    end
    wait_idle();
    chk("stress_bus_windows", bus_cnt - b0, exp_b);
    chk("stress_rd_pulses", rdv_cnt - r0, exp_r);
    chk("stress_queues_empty", busq.size() + rdq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
